// File: rtl/regfile_sb.sv
// Integer register file with NUM_RD registered read ports, one write port and a per-register busy scoreboard.
// Build option REGFILE_BYPASS_EN forwards a same-edge write to the read ports; otherwise reads see old data.
module regfile_sb_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              rf_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic [DATA_W-1:0] data_q,
  output logic              busy_q
);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] data_d;
  logic              busy_d;
  logic              wr_hit;
  logic              iss_hit;

  always_comb begin
    wr_hit  = wr_en && (wr_addr == addr) && (addr != '0);
    iss_hit = iss_en && (iss_addr == addr);
    data_d  = data_q;
    busy_d  = busy_q;
    if (en) begin
      if (addr == '0) begin
        data_d = '0;
        busy_d = 1'b0;
      end else if (wr_hit) begin
        // Same-edge clear is visible; a same-edge issue is only seen with bypass.
        data_d = BYPASS ? wr_data : rf_data;
        busy_d = BYPASS && iss_hit;
      end else begin
        data_d = rf_data;
        busy_d = rf_busy;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end
endmodule

module regfile_sb #(
  parameter int                 DATA_W  = 32,
  parameter int                 ADDR_W  = 5,
  parameter int                 NUM_RD  = 2,
  parameter int                 SP_IDX  = 29,
  parameter logic [DATA_W-1:0]  SP_INIT = 'h7fff_fffc
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]              regs_q [DEPTH];
  logic [DATA_W-1:0]              regs_d [DEPTH];
  logic [DEPTH-1:0]               busy_q;
  logic [DEPTH-1:0]               busy_d;
  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr_a;

  assign rd_addr_a = rd_addr;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_en && (wr_addr != '0)) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    // Applied after the clear so a newer producer wins over the retiring one.
    if (iss_en && (iss_addr != '0))
      busy_d[iss_addr] = 1'b1;
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= (i == SP_IDX && SP_IDX != 0) ? SP_INIT : '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_sb_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_port (
      .clk      (clk),
      .reset    (reset),
      .en       (rd_en[k]),
      .addr     (rd_addr_a[k]),
      .rf_data  (regs_q[rd_addr_a[k]]),
      .rf_busy  (busy_q[rd_addr_a[k]]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .data_q   (rd_data[k*DATA_W +: DATA_W]),
      .busy_q   (rd_busy[k])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, async-reset sequence, then random traffic vs a model.
module tb_regfile_sb;
  localparam int NRD = 2;
  localparam logic [31:0] SP = 32'h7fff_fffc;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NRD-1:0]    rd_en;
  logic [NRD*5-1:0]  rd_addr;
  logic [NRD*32-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [31:0]       wr_data;
  logic              iss_en;
  logic [4:0]        iss_addr;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(NRD), .SP_IDX(29), .SP_INIT(SP)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic we; logic [4:0] wa; logic [31:0] wd;
    logic ie; logic [4:0] ia;
    logic e0; logic [4:0] a0; logic e1; logic [4:0] a1;
    logic [31:0] d0; logic b0; logic [31:0] d1; logic b1;
  } vec_t;

  function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic ie, logic [4:0] ia,
                              logic e0, logic [4:0] a0, logic e1, logic [4:0] a1,
                              logic [31:0] d0, logic b0, logic [31:0] d1, logic b1);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia;
    v.e0 = e0; v.a0 = a0; v.e1 = e1; v.a1 = a1;
    v.d0 = d0; v.b0 = b0; v.d1 = d1; v.b1 = b1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0; iss_en = 0; iss_addr = 0;
    rd_en = '0; rd_addr = '0;
  endtask

  task automatic apply(input vec_t v);
    idle();
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd; iss_en = v.ie; iss_addr = v.ia;
    rd_en[0] = v.e0; rd_addr[4:0] = v.a0;
    rd_en[1] = v.e1; rd_addr[9:5] = v.a1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  vec_t tbl[17];

  // Reference model: architectural register and busy state plus last sampled port outputs.
  logic [31:0] mem [32];
  bit          bsy [32];
  logic [31:0] exp_d [NRD];
  bit          exp_b [NRD];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mem[i] = (i == 29) ? SP : 32'h0;
      bsy[i] = 0;
    end
    for (int k = 0; k < NRD; k++) begin
      exp_d[k] = 0; exp_b[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NRD; k++) begin
      if (rd_en[k]) begin
        logic [4:0] a;
        a = rd_addr[k*5 +: 5];
        if (a == 0) begin
          exp_d[k] = 0; exp_b[k] = 0;
        end else if (wr_en && wr_addr == a) begin
          exp_d[k] = BYP ? wr_data : mem[a];
          exp_b[k] = BYP ? (iss_en && iss_addr == a) : 1'b0;
        end else begin
          exp_d[k] = mem[a]; exp_b[k] = bsy[a];
        end
      end
    end
    if (wr_en && wr_addr != 0) begin
      mem[wr_addr] = wr_data;
      bsy[wr_addr] = 0;
    end
    if (iss_en && iss_addr != 0) bsy[iss_addr] = 1;
  endtask

  function automatic logic [4:0] raddr();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 5'd29 : 5'(r);
  endfunction

  initial begin
    logic [31:0] c7;
    logic [31:0] d9;
    logic [31:0] d3;
    c7 = BYP ? 32'hcafe_0001 : 32'h11;
    d9 = BYP ? 32'h55 : 32'h0;
    d3 = BYP ? 32'h77 : 32'h0;
    tbl[0]  = mk(0, 0, 0,            0, 0, 1, 29, 1, 1, SP, 0, 0, 0);
    tbl[1]  = mk(1, 0, 32'hdead_beef, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,            0, 0, 1, 0,  1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 7, 32'h11,       0, 0, 1, 29, 1, 5, SP, 0, 0, 0);
    tbl[4]  = mk(1, 7, 32'hcafe_0001, 0, 0, 1, 7, 1, 7, c7, 0, c7, 0);
    tbl[5]  = mk(0, 0, 0,            0, 0, 1, 7,  0, 3, 32'hcafe_0001, 0, c7, 0);
    tbl[6]  = mk(0, 0, 0,            1, 9, 1, 9,  1, 9, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0,            0, 0, 1, 9,  1, 9, 0, 1, 0, 1);
    tbl[8]  = mk(1, 9, 32'h55,       0, 0, 1, 9,  1, 9, d9, 0, d9, 0);
    tbl[9]  = mk(0, 0, 0,            0, 0, 1, 9,  1, 9, 32'h55, 0, 32'h55, 0);
    tbl[10] = mk(0, 0, 0,            1, 3, 1, 3,  0, 4, 0, 0, 32'h55, 0);
    tbl[11] = mk(1, 3, 32'h77,       1, 3, 1, 3,  1, 3, d3, BYP, d3, BYP);
    tbl[12] = mk(0, 0, 0,            0, 0, 1, 3,  1, 3, 32'h77, 1, 32'h77, 1);
    tbl[13] = mk(1, 3, 32'h99,       0, 0, 1, 29, 0, 7, SP, 0, 32'h77, 1);
    tbl[14] = mk(0, 0, 0,            1, 7, 1, 3,  0, 9, 32'h99, 0, 32'h77, 1);
    tbl[15] = mk(1, 5, 32'h1234,     0, 0, 1, 7,  0, 0, 32'hcafe_0001, 1, 32'h77, 1);
    tbl[16] = mk(0, 0, 0,            0, 0, 1, 5,  1, 3, 32'h1234, 0, 32'h99, 0);

    idle();
    reset = 1'b1;
    tick(); tick();
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("reset data p%0d", k), rd_data[k*32 +: 32], 32'h0);
      chk($sformatf("reset busy p%0d", k), {31'b0, rd_busy[k]}, 32'h0);
    end
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i]);
      tick();
      chk($sformatf("row%0d d0", i), rd_data[31:0], tbl[i].d0);
      chk($sformatf("row%0d b0", i), {31'b0, rd_busy[0]}, {31'b0, tbl[i].b0});
      chk($sformatf("row%0d d1", i), rd_data[63:32], tbl[i].d1);
      chk($sformatf("row%0d b1", i), {31'b0, rd_busy[1]}, {31'b0, tbl[i].b1});
    end

    // Async reset mid-cycle: outputs clear without an edge; a write/issue during reset is dropped.
    idle();
    wr_en = 1; wr_addr = 5; wr_data = 32'habcd; iss_en = 1; iss_addr = 5;
    reset = 1'b1;
    #2;
    chk("async d0", rd_data[31:0], 32'h0);
    chk("async d1", rd_data[63:32], 32'h0);
    chk("async busy", {30'b0, rd_busy[1:0]}, 32'h0);
    tick();
    reset = 1'b0;
    idle();
    rd_en[0] = 1; rd_addr[4:0] = 5; rd_en[1] = 1; rd_addr[9:5] = 29;
    tick();
    chk("post-reset r5 data", rd_data[31:0], 32'h0);
    chk("post-reset r5 busy", {31'b0, rd_busy[0]}, 32'h0);
    chk("post-reset sp", rd_data[63:32], SP);
    rd_addr[4:0] = 7; rd_addr[9:5] = 9;
    tick();
    chk("post-reset r7 busy", {31'b0, rd_busy[0]}, 32'h0);
    chk("post-reset r7 data", rd_data[31:0], 32'h0);
    chk("post-reset r9 data", rd_data[63:32], 32'h0);

    // Random traffic on a small index set to force collisions.
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      wr_en = ($urandom_range(0, 1) == 1);
      wr_addr = raddr();
      wr_data = $urandom;
      iss_en = ($urandom_range(0, 2) == 0);
      iss_addr = raddr();
      for (int k = 0; k < NRD; k++) begin
        rd_en[k] = ($urandom_range(0, 3) != 0);
        rd_addr[k*5 +: 5] = raddr();
      end
      model_step();
      tick();
      for (int k = 0; k < NRD; k++) begin
        chk($sformatf("rnd%0d d%0d", c, k), rd_data[k*32 +: 32], exp_d[k]);
        chk($sformatf("rnd%0d b%0d", c, k), {31'b0, rd_busy[k]}, {31'b0, exp_b[k]});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the pipeline's integer register file. It has N registered read ports and one write port. Write-to-read bypass is optional. A per-register busy scoreboard lets ID detect pending producers without a separate hazard table. Sits between ID (reads, issue marking) and WB (write, busy clear).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, index width; depth = 2**ADDR_W; register 0 hardwired to zero
NUM_RD, 2, number of read ports, legal 1..4
SP_IDX, 29, index loaded with SP_INIT on reset
SP_INIT, 32'h7fff_fffc, reset value of register SP_IDX

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-high; clears state immediately
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*ADDR_W  packed read indices, port k at [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed registered read data
rd_busy  out  NUM_RD  registered busy flag of the register read on that port
wr_en  in  1  write enable (WB)
wr_addr  in  ADDR_W  write index
wr_data  in  DATA_W  write data
iss_en  in  1  mark destination busy (ID issue)
iss_addr  in  ADDR_W  destination being issued

Behaviour:
- Reset (async, active-high):
  - all registers 0, except reg SP_IDX = SP_INIT
  - all busy bits 0; rd_data = 0; rd_busy = 0
  - state held while reset is high; a write/issue coincident with reset is discarded
- Read:
  - 1-cycle latency: rd_addr sampled at posedge with rd_en=1; rd_data/rd_busy valid after that edge
  - rd_en=0: that port's rd_data and rd_busy hold their previous values
  - index 0: always returns 0 data, busy 0
- Write:
  - at posedge, wr_en=1 and wr_addr!=0: reg[wr_addr] <= wr_data
  - writes to index 0 are ignored
- Read/write same edge, same nonzero index: governed by REGFILE_BYPASS_EN (below).
- Scoreboard, per register i != 0:
  - set when iss_en and iss_addr==i
  - cleared when wr_en and wr_addr==i
  - set and clear on the same edge for the same i: set wins (newer producer outstanding)
  - busy[0] is constant 0
  - issue to an already-busy register leaves it busy; clear of a non-busy register is a no-op
- rd_busy on a read port:
  - reflects busy after applying the same-edge clear
  - does not include a same-edge set: issue and read in the same cycle belong to different instructions, so the reader must not see its own destination
- Multiple read ports may address the same register; each returns identical data and busy.
- No internal arbitration or stalls; the block is always ready.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: when a read port samples an index that is written on the same edge (nonzero, wr_en=1), rd_data returns wr_data, and rd_busy returns 0 unless the same edge also issues to that index.
- Undefined: rd_data returns the pre-write stored value (old data). rd_busy still follows the clear-visible rule above.
- Either way, register contents after the edge are identical.

Test Plan:
- Reset → reg29 reads 32'h7fff_fffc; all other regs read 0; all rd_busy 0. Assert reset mid-cycle after writing reg5=32'h1234 → reg5 reads 0 with no clock edge needed for state clear.
- Write reg0=32'hdead_beef, then read reg0 on both ports → data 0, busy 0.
- Same edge: wr reg7=32'hcafe_0001, port0 reads reg7 (prior value 32'h11) → 32'hcafe_0001 with BYPASS_EN, 32'h11 without; next read → 32'hcafe_0001 in both builds.
- Issue reg9, then read reg9 next cycle → rd_busy=1. Write reg9=32'h55 → next read gives busy 0, data 32'h55.
- Same edge: issue reg3 and write reg3 (reg3 busy beforehand) → busy stays 1 on the following read.
- rd_en=0 on port1 for 3 cycles while rd_addr changes and reg contents change → rd_data1/rd_busy1 hold the last sampled values; NUM_RD=4 build passes all of the above on every port.
